systolic_matmul_nxn: RTL and testbench

Parametrised N x N integer matrix multiplier built on an output-stationary systolic PE grid; computes C = A x B.
Successor to the fixed 3x3, 5-bit multiplier: adds generic size and width, a start/busy/done handshake, internal input skewing, an asynchronous reset and an optional signed mode.
Sits between the operand buffers of the convolution datapath (im2col tile, kernel tile) and the result writeback.

---
 rtl/matmul_pkg.sv | 30 +++
 rtl/systolic_pe.sv | 66 ++++++
 rtl/systolic_matmul_nxn.sv | 128 ++++++++++++
 tb/tb_systolic_matmul_nxn.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the N x N output-stationary systolic matrix multiplier.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_DEFAULT = 3;
    localparam int STEPS     = 3*N_DEFAULT - 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Number of FEED cycles for an n x n grid: skew in, n terms, skew out.
    function automatic int steps(input int n);
        return 3*n - 2;
    endfunction

    // Bit offset of element (r,c) in a row-major flattened n x n matrix of w-bit elements.
    function automatic int elem_off(input int r, input int c, input int n, input int w);
        return (r*n + c)*w;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: multiply-accumulate, forwards a right and b down via one register each.
// Signed arithmetic selected by MATMUL_SIGNED_EN.
module systolic_pe
    import matmul_pkg::*;
#(
    parameter int DW = 5,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    output logic [DW-1:0] a_out,
    output logic [DW-1:0] b_out,
    output logic [AW-1:0] acc
);

    logic [DW-1:0] a_p1;
    logic [DW-1:0] b_p1;
    logic [AW-1:0] acc_p1;

    // Full-width product extended to the accumulator width.
    function automatic logic [AW-1:0] ext_prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef MATMUL_SIGNED_EN
        logic signed [2*DW-1:0] sa;
        logic signed [2*DW-1:0] sb;
        logic signed [2*DW-1:0] p;
        sa = {{DW{a[DW-1]}}, a};
        sb = {{DW{b[DW-1]}}, b};
        p  = sa * sb;
        return {{(AW-2*DW){p[2*DW-1]}}, p};
`else
        logic [2*DW-1:0] ua;
        logic [2*DW-1:0] ub;
        logic [2*DW-1:0] p;
        ua = {{DW{1'b0}}, a};
        ub = {{DW{1'b0}}, b};
        p  = ua * ub;
        return {{(AW-2*DW){1'b0}}, p};
`endif
    endfunction

    // stage p1: operand forwarding and accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_p1   <= '0;
            b_p1   <= '0;
            acc_p1 <= '0;
        end else if (clr) begin
            a_p1   <= '0;
            b_p1   <= '0;
            acc_p1 <= '0;
        end else if (en) begin
            a_p1   <= a_in;
            b_p1   <= b_in;
            acc_p1 <= acc_p1 + ext_prod(a_in, b_in);
        end
    end

    assign a_out = a_p1;
    assign b_out = b_p1;
    assign acc   = acc_p1;

endmodule

// File: rtl/systolic_matmul_nxn.sv
// N x N integer matrix multiplier C = A x B on an output-stationary systolic grid with start/busy/done.
// Define MATMUL_SIGNED_EN for two's-complement operands and results.
module systolic_matmul_nxn
    import matmul_pkg::*;
#(
    parameter int N  = 3,
    parameter int DW = 5,
    parameter int AW = 2*DW + clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N*N*DW-1:0] a_flat,
    input  logic [N*N*DW-1:0] b_flat,
    output logic              busy,
    output logic              done,
    output logic [N*N*AW-1:0] c_flat
);

    localparam int NSTEP = steps(N);
    localparam int KW    = clog2(NSTEP);

    state_t            state_q;
    state_t            state_d;
    logic [KW-1:0]     k_q;
    logic [N*N*DW-1:0] a_q;
    logic [N*N*DW-1:0] b_q;
    logic [N*N*AW-1:0] c_q;
    logic [N*N*AW-1:0] acc_all;
    logic              clr;
    logic              en;
    logic              last;

    logic [DW-1:0] a_edge [N];
    logic [DW-1:0] b_edge [N];
    logic [DW-1:0] a_h    [N][N+1];
    logic [DW-1:0] b_v    [N+1][N];
    logic          unused_links;

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        en      = 1'b0;
        last    = (k_q == KW'(NSTEP-1));
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    state_d = FEED;
                end
            end
            FEED: begin
                en = 1'b1;
                if (last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            if (clr) begin
                a_q <= a_flat;
                b_q <= b_flat;
                k_q <= '0;
            end else if (en && !last) begin
                k_q <= k_q + KW'(1);
            end
            if (state_q == DONE) c_q <= acc_all;
        end
    end

    // Edge skew: row i starts i cycles late, column j starts j cycles late.
    always_comb begin
        int idx;
        for (int i = 0; i < N; i++) begin
            a_edge[i] = '0;
            b_edge[i] = '0;
            idx = int'(k_q) - i;
            if (idx >= 0 && idx < N) begin
                a_edge[i] = a_q[elem_off(i, idx, N, DW) +: DW];
                b_edge[i] = b_q[elem_off(idx, i, N, DW) +: DW];
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        assign a_h[gi][0] = a_edge[gi];
        assign b_v[0][gi] = b_edge[gi];
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            systolic_pe #(
                .DW(DW),
                .AW(AW)
            ) u_pe (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (clr),
                .en    (en),
                .a_in  (a_h[gi][gj]),
                .b_in  (b_v[gi][gj]),
                .a_out (a_h[gi][gj+1]),
                .b_out (b_v[gi+1][gj]),
                .acc   (acc_all[elem_off(gi, gj, N, AW) +: AW])
            );
        end
    end

    // Operands leaving the right and bottom edges have no consumer.
    always_comb begin
        unused_links = 1'b0;
        for (int i = 0; i < N; i++) begin
            unused_links = unused_links ^ (^a_h[i][N]) ^ (^b_v[N][i]);
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign c_flat = done ? acc_all : c_q;

endmodule

// File: tb/tb_systolic_matmul_nxn.sv
// Scoreboard bench for systolic_matmul_nxn: directed and random matrices against a plain triple-loop model.
module tb_systolic_matmul_nxn;

    localparam int N  = 3;
    localparam int DW = 5;
    localparam int AW = 12;
    localparam int NN = N*N;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [NN*DW-1:0]  a_flat;
    logic [NN*DW-1:0]  b_flat;
    logic              busy;
    logic              done;
    logic [NN*AW-1:0]  c_flat;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int n_accept = 0;
    logic [NN*AW-1:0] exp_q [$];
    logic [NN*AW-1:0] last_exp;

    always #5 clk = ~clk;

    systolic_matmul_nxn #(
        .N (N),
        .DW(DW),
        .AW(AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a_flat(a_flat),
        .b_flat(b_flat),
        .busy  (busy),
        .done  (done),
        .c_flat(c_flat)
    );

    function automatic longint elem(input logic [NN*DW-1:0] m, input int r, input int c);
        logic [DW-1:0] e;
        e = m[(r*N+c)*DW +: DW];
`ifdef MATMUL_SIGNED_EN
        return longint'($signed(e));
`else
        return longint'(e);
`endif
    endfunction

    function automatic logic [NN*AW-1:0] ref_mm(input logic [NN*DW-1:0] a, input logic [NN*DW-1:0] b);
        logic [NN*AW-1:0] c;
        longint s;
        c = '0;
        for (int r = 0; r < N; r++) begin
            for (int cc = 0; cc < N; cc++) begin
                s = 0;
                for (int m = 0; m < N; m++) s += elem(a, r, m) * elem(b, m, cc);
                c[(r*N+cc)*AW +: AW] = s[AW-1:0];
            end
        end
        return c;
    endfunction

    function automatic logic [NN*DW-1:0] fill(input int v);
        logic [NN*DW-1:0] m;
        for (int i = 0; i < NN; i++) m[i*DW +: DW] = DW'(v);
        return m;
    endfunction

    function automatic logic [NN*DW-1:0] pack_a(input int v [NN]);
        logic [NN*DW-1:0] m;
        for (int i = 0; i < NN; i++) m[i*DW +: DW] = DW'(v[i]);
        return m;
    endfunction

    function automatic logic [NN*AW-1:0] pack_c(input int v [NN]);
        logic [NN*AW-1:0] m;
        for (int i = 0; i < NN; i++) m[i*AW +: AW] = AW'(v[i]);
        return m;
    endfunction

    function automatic logic [NN*DW-1:0] rnd_mat();
        logic [NN*DW-1:0] m;
        for (int i = 0; i < NN; i++) m[i*DW +: DW] = DW'($urandom);
        return m;
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [NN*AW-1:0] act, input logic [NN*AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every done pops one expected matrix.
    initial begin
        logic [NN*AW-1:0] e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_done actual=done required=no_done");
                end else begin
                    e = exp_q.pop_front();
                    check_vec("c_result", c_flat, e);
                end
            end
        end
    end

    task automatic do_start(input logic [NN*DW-1:0] a, input logic [NN*DW-1:0] b, input bit hold);
        @(negedge clk);
        check_int("idle_busy", int'(busy), 0);
        a_flat = a;
        b_flat = b;
        start  = 1'b1;
        last_exp = ref_mm(a, b);
        exp_q.push_back(last_exp);
        n_accept++;
        @(posedge clk);
        #1;
        if (!hold) begin
            start  = 1'b0;
            a_flat = rnd_mat();
            b_flat = rnd_mat();
        end
    endtask

    task automatic wait_done(input bit scramble, input string tag);
        int t;
        int busy_bad;
        bit seen;
        seen = 1'b0;
        busy_bad = 0;
        for (t = 1; t <= 3*N + 4; t++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (scramble) begin
                if (t <= 5) begin
                    start  = 1'b1;
                    a_flat = rnd_mat();
                    b_flat = rnd_mat();
                end else begin
                    start = 1'b0;
                end
            end
        end
        check_int({tag, "_latency"}, seen ? t : -1, 3*N - 1);
        check_int({tag, "_busy"}, busy_bad, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq [NN];
        int ident [NN];
        int prod_seq [NN];
        int d0;

        for (int i = 0; i < NN; i++) begin
            seq[i]   = i + 1;
            ident[i] = ((i / N) == (i % N)) ? 1 : 0;
        end
        prod_seq = '{30, 36, 42, 66, 81, 96, 102, 126, 150};

        // Reset with start asserted: nothing may be accepted.
        rst_n  = 1'b0;
        start  = 1'b1;
        a_flat = rnd_mat();
        b_flat = rnd_mat();
        repeat (3) @(negedge clk);
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_done", int'(done), 0);
        check_vec("rst_c", c_flat, '0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_int("post_rst_busy", int'(busy), 0);

        do_start(fill(4), fill(1), 1'b0);
        wait_done(1'b0, "fill4x1");
        check_vec("c_all12", c_flat, pack_c('{12, 12, 12, 12, 12, 12, 12, 12, 12}));

        do_start(pack_a(ident), pack_a(seq), 1'b0);
        wait_done(1'b0, "ident");
        check_vec("c_eq_b", c_flat, pack_c(seq));

        do_start(pack_a(seq), pack_a(seq), 1'b0);
        wait_done(1'b0, "b2b");
        check_vec("c_seq_sq", c_flat, pack_c(prod_seq));
        repeat (3) @(negedge clk);
        check_vec("c_hold", c_flat, last_exp);

`ifdef MATMUL_SIGNED_EN
        do_start(fill(-16), fill(-16), 1'b0);
        wait_done(1'b0, "bound");
        check_vec("c_bound", c_flat, pack_c('{768, 768, 768, 768, 768, 768, 768, 768, 768}));
`else
        do_start(fill(31), fill(31), 1'b0);
        wait_done(1'b0, "bound");
        check_vec("c_bound", c_flat, pack_c('{2883, 2883, 2883, 2883, 2883, 2883, 2883, 2883, 2883}));
`endif

        // start held high with operands changing during FEED.
        d0 = done_cnt;
        do_start(rnd_mat(), rnd_mat(), 1'b1);
        wait_done(1'b1, "held");
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_int("held_one_done", done_cnt - d0, 1);

        // Reset in the middle of FEED.
        do_start(rnd_mat(), rnd_mat(), 1'b0);
        repeat (4) @(negedge clk);
        d0 = done_cnt;
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        n_accept--;
        #1;
        check_int("abort_busy", int'(busy), 0);
        check_int("abort_done", int'(done), 0);
        check_vec("abort_c", c_flat, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_int("abort_no_done", done_cnt - d0, 0);
        check_vec("abort_c_idle", c_flat, '0);
        do_start(rnd_mat(), rnd_mat(), 1'b0);
        wait_done(1'b0, "after_abort");

        for (int n = 0; n < 20; n++) begin
            do_start(rnd_mat(), rnd_mat(), 1'b0);
            wait_done(1'b0, "rand");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        check_int("done_count", done_cnt, n_accept);
        check_int("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
